// File: rtl/dtw_pkg.sv
// -----------------------------------------------------------------------------
// dtw_pkg
// Shared definitions for the word-recognition path: packed-word geometry,
// character code type, ASCII constants and the word_tx state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package dtw_pkg;

    localparam int CHAR_W    = 8;
    localparam int MAX_CHARS = 15;
    localparam int WORD_W    = MAX_CHARS * CHAR_W;

    // One slot of the packed word: 0 = padding/end, 1..26 = 'A'..'Z'
    typedef logic [CHAR_W-1:0] char_code_t;

    localparam logic [7:0] ASCII_NUL        = 8'h00;
    localparam logic [7:0] ASCII_BASE       = 8'h40;
    localparam logic [7:0] ASCII_QMARK      = 8'h3F;
    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] CODE_LAST_LETTER = 8'd26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        TERM = 2'd2,
        DONE = 2'd3
    } wtx_state_t;

endpackage

// File: rtl/wtx_char_enc.sv
// -----------------------------------------------------------------------------
// wtx_char_enc
// Combinational letter-code to ASCII encoder, shared with the display path.
//   code  in  8  slot code (1..26 letters, 0 padding, others invalid)
//   ascii out 8  'A'..'Z' for 1..26, '?' for 27..255, NUL for padding
// -----------------------------------------------------------------------------
module wtx_char_enc
    import dtw_pkg::*;
(
    input  logic [7:0] code,
    output logic [7:0] ascii
);

    // Map one slot code onto its printable character
    always_comb begin
        ascii = ASCII_NUL;
        if (code == 8'd0) begin
            ascii = ASCII_NUL;
        end else if (code <= CODE_LAST_LETTER) begin
            ascii = ASCII_BASE + code;
        end else begin
            ascii = ASCII_QMARK;
        end
    end

endmodule

// File: rtl/word_tx.sv
// -----------------------------------------------------------------------------
// word_tx
// Captures a packed 15-slot word on a start pulse and streams it out as ASCII
// bytes over a valid/ready interface, one byte per cycle while ready is held.
//
// Ports:
//   i_WTX_clk    in   1    clock, rising edge
//   i_WTX_rst_n  in   1    asynchronous active-low reset
//   i_WTX_start  in   1    one-cycle load pulse (accepted only when idle)
//   i_WTX_word   in   120  packed word, slot 0 in bits [7:0]
//   i_WTX_ready  in   1    downstream accepts a byte this cycle
//   o_WTX_valid  out  1    o_WTX_data holds a byte
//   o_WTX_data   out  8    ASCII byte
//   o_WTX_busy   out  1    high from accepted start until the done cycle
//   o_WTX_done   out  1    one-cycle pulse after the last byte is accepted
//   o_WTX_len    out  4    letters sent, valid from done until next start
//
// Build option: define WTX_NEWLINE_EN to append CR LF after every word.
// -----------------------------------------------------------------------------
module word_tx
    import dtw_pkg::*;
(
    input  logic              i_WTX_clk,
    input  logic              i_WTX_rst_n,
    input  logic              i_WTX_start,
    input  logic [WORD_W-1:0] i_WTX_word,
    input  logic              i_WTX_ready,
    output logic              o_WTX_valid,
    output logic [7:0]        o_WTX_data,
    output logic              o_WTX_busy,
    output logic              o_WTX_done,
    output logic [3:0]        o_WTX_len
);

    wtx_state_t              state_r, state_nxt_s;
    logic [WORD_W-1:0]       word_r, word_nxt_s;
    logic [3:0]              idx_r, idx_nxt_s;
    logic [3:0]              len_r, len_nxt_s;
    logic                    valid_r, valid_nxt_s;
    logic [7:0]              data_r, data_nxt_s;
    logic                    busy_r, busy_nxt_s;
    logic                    done_r, done_nxt_s;
`ifdef WTX_NEWLINE_EN
    logic                    term_r, term_nxt_s;   // 0: CR on the bus, 1: LF
`endif

    logic                    fire_s;
    logic                    start_ok_s;
    logic [3:0]              idx_look_s;
    logic [WORD_W+CHAR_W-1:0] word_ext_s;
    char_code_t              slot_s;
    logic [7:0]              slot_ascii_s;
    logic                    end_of_word_s;

    assign fire_s = valid_r & i_WTX_ready;

    // The done-pulse cycle is treated as part of the finishing sequence, so a
    // start coinciding with it is dropped just like one in the DONE state.
    assign start_ok_s = i_WTX_start & (state_r == IDLE) & ~done_r;

    // Slot lookahead: the byte registered at this edge belongs to the slot
    // after the one being accepted, which keeps one byte per cycle.
    always_comb begin
        if (fire_s) begin
            idx_look_s = idx_r + 4'd1;
        end else begin
            idx_look_s = idx_r;
        end
    end

    // A zero pad slot above the word makes idx == MAX_CHARS read as end of word
    assign word_ext_s    = {{CHAR_W{1'b0}}, word_r};
    assign slot_s        = word_ext_s[{idx_look_s, 3'b000} +: CHAR_W];
    assign end_of_word_s = (slot_s == 8'd0) || (idx_look_s == 4'(MAX_CHARS));

    wtx_char_enc u_enc (
        .code  (slot_s),
        .ascii (slot_ascii_s)
    );

    // Next-state and next-output logic
    always_comb begin
        state_nxt_s = state_r;
        word_nxt_s  = word_r;
        idx_nxt_s   = idx_r;
        len_nxt_s   = len_r;
        valid_nxt_s = valid_r;
        data_nxt_s  = data_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
`ifdef WTX_NEWLINE_EN
        term_nxt_s  = term_r;
`endif
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    word_nxt_s  = i_WTX_word;
                    idx_nxt_s   = 4'd0;
                    len_nxt_s   = 4'd0;
                    busy_nxt_s  = 1'b1;
                    valid_nxt_s = 1'b0;
                    data_nxt_s  = 8'h00;
                    state_nxt_s = SEND;
                end else begin
                    valid_nxt_s = 1'b0;
                    busy_nxt_s  = 1'b0;
                end
            end
            SEND: begin
                if (valid_r && !i_WTX_ready) begin
                    // Stall: hold the presented byte unchanged
                    state_nxt_s = SEND;
                end else begin
                    if (fire_s) begin
                        idx_nxt_s = idx_look_s;
                        if (len_r == 4'd15) begin
                            len_nxt_s = len_r;
                        end else begin
                            len_nxt_s = len_r + 4'd1;
                        end
                    end else begin
                        idx_nxt_s = idx_r;
                    end
                    if (end_of_word_s) begin
`ifdef WTX_NEWLINE_EN
                        valid_nxt_s = 1'b1;
                        data_nxt_s  = ASCII_CR;
                        term_nxt_s  = 1'b0;
                        state_nxt_s = TERM;
`else
                        valid_nxt_s = 1'b0;
                        data_nxt_s  = 8'h00;
                        state_nxt_s = DONE;
`endif
                    end else begin
                        valid_nxt_s = 1'b1;
                        data_nxt_s  = slot_ascii_s;
                    end
                end
            end
`ifdef WTX_NEWLINE_EN
            TERM: begin
                if (fire_s) begin
                    if (!term_r) begin
                        data_nxt_s = ASCII_LF;
                        term_nxt_s = 1'b1;
                    end else begin
                        valid_nxt_s = 1'b0;
                        data_nxt_s  = 8'h00;
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = TERM;
                end
            end
`endif
            DONE: begin
                valid_nxt_s = 1'b0;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                valid_nxt_s = 1'b0;
                busy_nxt_s  = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and registered-output update; reset drops any partial word
    always_ff @(posedge i_WTX_clk or negedge i_WTX_rst_n) begin
        if (!i_WTX_rst_n) begin
            state_r <= IDLE;
            word_r  <= '0;
            idx_r   <= 4'd0;
            len_r   <= 4'd0;
            valid_r <= 1'b0;
            data_r  <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef WTX_NEWLINE_EN
            term_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            word_r  <= word_nxt_s;
            idx_r   <= idx_nxt_s;
            len_r   <= len_nxt_s;
            valid_r <= valid_nxt_s;
            data_r  <= data_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
`ifdef WTX_NEWLINE_EN
            term_r  <= term_nxt_s;
`endif
        end
    end

    assign o_WTX_valid = valid_r;
    assign o_WTX_data  = data_r;
    assign o_WTX_busy  = busy_r;
    assign o_WTX_done  = done_r;
    assign o_WTX_len   = len_r;

endmodule

// File: tb/tb_word_tx.sv
// -----------------------------------------------------------------------------
// tb_word_tx
// Scoreboard bench for word_tx: expected bytes are derived from each packed
// word by a small model and popped as the DUT hands bytes over.
// -----------------------------------------------------------------------------
module tb_word_tx;

`ifdef WTX_NEWLINE_EN
    localparam int NL = 2;
`else
    localparam int NL = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [119:0] word;
    logic         ready;
    logic         valid;
    logic [7:0]   data;
    logic         busy;
    logic         done;
    logic [3:0]   len;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int         accepted_cnt = 0;
    int         done_cnt     = 0;
    int         valid_cycles = 0;
    logic       prev_valid   = 1'b0;
    logic       prev_fire    = 1'b0;
    logic [7:0] prev_data    = 8'h00;

    always #5 clk = ~clk;

    word_tx dut (
        .i_WTX_clk   (clk),
        .i_WTX_rst_n (rst_n),
        .i_WTX_start (start),
        .i_WTX_word  (word),
        .i_WTX_ready (ready),
        .o_WTX_valid (valid),
        .o_WTX_data  (data),
        .o_WTX_busy  (busy),
        .o_WTX_done  (done),
        .o_WTX_len   (len)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: push the byte stream a word should produce, return letters
    function automatic int model_word(input logic [119:0] w);
        int         n;
        logic [7:0] c;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            c = w[i*8 +: 8];
            if (c == 8'd0) break;
            if (c <= 8'd26) exp_q.push_back(8'h40 + c);
            else            exp_q.push_back(8'h3F);
            n++;
        end
        if (NL == 2) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
        return n;
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_fire  = 1'b0;
        end else begin
            if (prev_valid && !prev_fire) begin
                check_val("stall_valid", {31'd0, valid}, 32'd1);
                check_val("stall_data", {24'd0, data}, {24'd0, prev_data});
            end
            if (valid) valid_cycles++;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_byte", {24'd0, data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_val("byte", {24'd0, data}, {24'd0, e});
                end
                accepted_cnt++;
            end
            if (done) done_cnt++;
            prev_valid = valid;
            prev_fire  = valid && ready;
            prev_data  = data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one word; optionally stall, inject a start while busy, or abort by reset
    task automatic run_word(input logic [119:0] w, input int hold_at, input bit inject,
                            input int abort_at, input bit check_lat);
        int letters;
        int hold_left;
        bit held;
        bit got_done;
        bit aborted;
        letters      = model_word(w);
        accepted_cnt = 0;
        valid_cycles = 0;
        hold_left    = 0;
        held         = 1'b0;
        got_done     = 1'b0;
        aborted      = 1'b0;
        word  = w;
        start = 1'b1;
        ready = 1'b1;
        tick();
        start = 1'b0;
        word  = ~w;
        check_val("busy_after_start", {31'd0, busy}, 32'd1);
        check_val("valid_after_start", {31'd0, valid}, 32'd0);
        check_val("len_cleared", {28'd0, len}, 32'd0);
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (n == 1)
                check_val("first_valid", {31'd0, valid}, ((letters + NL) > 0) ? 32'd1 : 32'd0);
            if (done) begin
                got_done = 1'b1;
                if (check_lat) check_val("done_latency", n, letters + 2 + NL);
                break;
            end
            if (abort_at > 0 && accepted_cnt == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_val("rst_valid", {31'd0, valid}, 32'd0);
                check_val("rst_busy", {31'd0, busy}, 32'd0);
                check_val("rst_done", {31'd0, done}, 32'd0);
                exp_q.delete();
                aborted = 1'b1;
                break;
            end
            if (inject && n == 3) begin
                start = 1'b1;
                word  = {15{8'h02}};
            end else begin
                start = 1'b0;
            end
            if (hold_left > 0) begin
                check_val("hold_valid", {31'd0, valid}, 32'd1);
                if (exp_q.size() > 0) check_val("hold_head", {24'd0, data}, {24'd0, exp_q[0]});
                hold_left--;
                if (hold_left == 0) ready = 1'b1;
            end else if (!held && hold_at >= 0 && accepted_cnt == hold_at) begin
                held      = 1'b1;
                ready     = 1'b0;
                hold_left = 3;
                check_val("hold_first", {24'd0, data}, {24'd0, exp_q[0]});
            end
        end
        start = 1'b0;
        if (!aborted) begin
            check_val("done_seen", {31'd0, got_done}, 32'd1);
            check_val("len", {28'd0, len}, letters);
            check_val("queue_empty", exp_q.size(), 32'd0);
            check_val("busy_at_done", {31'd0, busy}, 32'd0);
            check_val("valid_at_done", {31'd0, valid}, 32'd0);
            tick();
            check_val("done_width", {31'd0, done}, 32'd0);
            check_val("len_held", {28'd0, len}, letters);
        end
        ready = 1'b1;
    endtask

    initial begin
        logic [119:0] w;
        int           dsnap;
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        word  = '0;
        tick();
        tick();
        check_val("reset_valid", {31'd0, valid}, 32'd0);
        check_val("reset_data", {24'd0, data}, 32'd0);
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        check_val("reset_done", {31'd0, done}, 32'd0);
        check_val("reset_len", {28'd0, len}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: GALLERY, ready held high
        run_word({64'h0, 8'h19, 8'h12, 8'h05, 8'h0C, 8'h0C, 8'h01, 8'h07}, -1, 1'b0, 0, 1'b1);
        // 2: GALLERY with 3-cycle stall while 'A' is presented
        run_word({64'h0, 8'h19, 8'h12, 8'h05, 8'h0C, 8'h0C, 8'h01, 8'h07}, 1, 1'b0, 0, 1'b0);
        // 3: empty word
        run_word('0, -1, 1'b0, 0, 1'b1);
        if (NL == 0) check_val("empty_no_valid", valid_cycles, 32'd0);
        // 4: full word of 'Z', then invalid codes mid-word
        run_word({15{8'h1A}}, -1, 1'b0, 0, 1'b1);
        w = {15{8'h1A}};
        w[31:24] = 8'h1B;
        w[63:56] = 8'hFF;
        run_word(w, -1, 1'b0, 0, 1'b1);
        // padding: slots after the first zero are ignored
        run_word({{12{8'h05}}, 8'h00, 8'h04, 8'h03}, -1, 1'b0, 0, 1'b1);
        // 5: start with a different word while busy
        run_word({64'h0, 8'h19, 8'h12, 8'h05, 8'h0C, 8'h0C, 8'h01, 8'h07}, -1, 1'b1, 0, 1'b1);
        // 6: reset after the third byte
        run_word({64'h0, 8'h19, 8'h12, 8'h05, 8'h0C, 8'h0C, 8'h01, 8'h07}, -1, 1'b0, 3, 1'b0);
        tick();
        rst_n = 1'b1;
        dsnap = done_cnt;
        for (int k = 0; k < 6; k++) tick();
        check_val("no_done_after_abort", done_cnt, dsnap);
        check_val("idle_after_abort", {31'd0, busy}, 32'd0);
        run_word({64'h0, 8'h19, 8'h12, 8'h05, 8'h0C, 8'h0C, 8'h01, 8'h07}, -1, 1'b0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/word_tx.md
Name: word_tx

Overview:
Transmit end of the word-recognition path: captures the 120-bit packed word from DTW on its finish pulse and streams it out one ASCII character at a time over a valid/ready byte interface (UART TX or display driver downstream).
Packed format: 15 slots of 8 bits, slot 0 in bits [7:0] is the first letter; codes 1..26 = 'A'..'Z'; code 0 = padding / end of word.
Example: the packed code for "GALLERY" leaves as bytes 0x47 0x41 0x4C 0x4C 0x45 0x52 0x59.

Parameters:
MAX_CHARS, 15, character slots per word.
CHAR_W, 8, bits per slot.
WORD_W, MAX_CHARS*CHAR_W (120), packed word width.

Ports:
i_WTX_clk  in  1  clock, rising edge.
i_WTX_rst_n  in  1  asynchronous active-low reset.
i_WTX_start  in  1  one-cycle load pulse; driven by o_DTW_finish.
i_WTX_word  in  WORD_W  packed word; driven by o_DTW_word, sampled only on accepted start.
i_WTX_ready  in  1  downstream can take a byte this cycle.
o_WTX_valid  out  1  o_WTX_data holds a byte.
o_WTX_data  out  8  ASCII byte.
o_WTX_busy  out  1  high from accepted start until the cycle of o_WTX_done.
o_WTX_done  out  1  one-cycle pulse after the last byte is accepted.
o_WTX_len  out  4  number of letters sent; valid from the done pulse until the next accepted start.

Behaviour:
- Reset (asynchronous, active low): all outputs 0, state IDLE, internal word register cleared.
- State IDLE:
  - Start is accepted only in IDLE.
  - On an accepted start: latch i_WTX_word, clear the slot index and o_WTX_len, set busy, go to SEND.
- State SEND:
  - Current slot = word[idx*8 +: 8].
  - Slot code 0, or idx == MAX_CHARS: end of word; go to TERM (macro on) or DONE (macro off).
  - Otherwise assert valid with the encoded byte.
  - Encoding: code 1..26 -> 0x40+code; code 27..255 -> 0x3F ('?').
  - A transfer completes on any edge where valid && ready. Then idx and o_WTX_len increment, and the next slot is presented in the following cycle.
  - Valid may stay high across back-to-back transfers; throughput is one byte per cycle while ready is held.
  - Valid and data are held stable until accepted. Valid never drops without a transfer, except on reset.
- Latency:
  - First byte: start sampled at edge N gives valid high after edge N+1.
  - Empty word (slot 0 == 0), macro off: done pulses after edge N+2 and no valid is ever asserted.
- Padding: slots after the first zero are ignored even if non-zero.
- State DONE:
  - Valid low, done high for one cycle, busy low in that same cycle, then IDLE.
  - A start arriving in the DONE cycle is ignored.
- Start while busy: ignored; the word register is unchanged.
- Ready while valid is low: ignored.
- Reset mid-transfer: immediate return to IDLE; the partial word is dropped and no done pulse is produced.
- o_WTX_len saturates at 15 and never wraps.

Optional Feature:
- Macro WTX_NEWLINE_EN.
- Defined: state TERM follows the last letter and sends 0x0D then 0x0A under the same handshake, then goes to DONE. An empty word sends only CR LF. o_WTX_len excludes the terminator bytes.
- Undefined: TERM is not compiled, and SEND goes straight to DONE.

Decomposition:
- Shared package dtw_pkg holds:
  - CHAR_W, MAX_CHARS, WORD_W;
  - the char code typedef;
  - ASCII constants (ASCII_BASE 0x40, ASCII_QMARK 0x3F, ASCII_CR, ASCII_LF);
  - the wtx_state_t enum {IDLE, SEND, TERM, DONE}.
- Sub-module wtx_char_enc: combinational 8-bit code -> ASCII encoder, reusable by the display path. Everything else stays inline.

Test Plan:
1. GALLERY packed word, ready held high -> bytes 47,41,4C,4C,45,52,59 on 7 consecutive cycles; done one cycle after the last byte; len=7.
2. Same word, ready low for 3 cycles while 0x41 is presented -> data stays 0x41 with valid high throughout; no byte is skipped or duplicated.
3. All-zero word -> no valid, done after edge N+2, len=0. With WTX_NEWLINE_EN defined: only 0D,0A are sent.
4. 15 non-zero slots (code 0x1A each) -> exactly 15 bytes of 0x5A, len=15. A slot code 0x1B mid-word -> 0x3F at that position.
5. Second start pulse and a different word during busy -> output sequence is unchanged from the first word.
6. rst_n low after the 3rd byte -> valid, busy and done go 0 at once; no done pulse follows; a new start afterwards sends from slot 0.
